// File: rtl/dram_addr_gen.sv
// -----------------------------------------------------------------------------
// dram_addr_gen
//   Drains full blocks from eight reorder buffers into DRAM as a sequence of
//   fixed-length write bursts. A round-robin arbiter picks one ready buffer.
//   That buffer is then held for a whole block of BLOCK_WORDS 256-bit words.
//   The words are read one at a time and written out in bursts of BURST_LEN.
//   The write address is a free-running burst base address. It keeps its value
//   between blocks, so successive blocks land in consecutive address ranges.
//
// Parameters
//   BLOCK_WORDS : words drained per grant (multiple of BURST_LEN)
//   BURST_LEN   : words per DRAM write burst (1..16)
//
// Ports
//   clk, rst                 : clock; asynchronous active-high reset
//   triggering_time_stamp    : timestamp of first trigger (valid with status)
//   triggering_status        : trigger flag from global coordinator
//   BRAM_ready_mask[7:0]     : buffer i holds a full block
//   BRAM_rd_data[255:0]      : selected buffer read data, 1 cycle after request
//   BRAM_rd_request[7:0]     : one-hot read strobe for the granted buffer
//   BRAM_Sel[2:0]            : granted buffer index (external data mux)
//   DRAM_Wait_Request        : DRAM stall; word taken when enable & !wait
//   DRAM_Write_Enable        : write data valid
//   DRAM_Write_Burst_Begin   : first word of a burst
//   DRAM_Write_Burst_Count   : burst length (BURST_LEN while writing)
//   DRAM_Write_Addr[24:0]    : burst base address, word units
//   DRAM_Write_Data[255:0]   : write data
//   MASK_output              : address-mask pulse (optional feature)
//
// Build option
//   DRAM_ADDR_MASK_EN : when defined, a rising edge on triggering_status
//   captures the current write address and timestamp internally. It also
//   pulses MASK_output for one cycle. When undefined, MASK_output is tied to 0.
// -----------------------------------------------------------------------------
module dram_addr_gen #(
  parameter int BLOCK_WORDS = 128,
  parameter int BURST_LEN   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  triggering_time_stamp,
  input  logic         triggering_status,
  input  logic [7:0]   BRAM_ready_mask,
  input  logic [255:0] BRAM_rd_data,
  output logic [7:0]   BRAM_rd_request,
  output logic [2:0]   BRAM_Sel,
  input  logic         DRAM_Wait_Request,
  output logic         DRAM_Write_Enable,
  output logic         DRAM_Write_Burst_Begin,
  output logic [4:0]   DRAM_Write_Burst_Count,
  output logic [24:0]  DRAM_Write_Addr,
  output logic [255:0] DRAM_Write_Data,
  output logic         MASK_output
);

  localparam int NUM_BUF = 8;
  localparam int WCW     = $clog2(BLOCK_WORDS + 1);

  localparam logic [WCW-1:0] LAST_WORD = WCW'(BLOCK_WORDS - 1);
  localparam logic [4:0]     LAST_BEAT = 5'(BURST_LEN - 1);
  localparam logic [4:0]     BURST_CNT = 5'(BURST_LEN);
  localparam logic [24:0]    ADDR_STEP = 25'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > 16 || (BLOCK_WORDS % BURST_LEN) != 0) begin : g_bad_cfg
    $error("dram_addr_gen: illegal BLOCK_WORDS/BURST_LEN combination");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    RD    = 3'd2,
    LATCH = 3'd3,
    WR    = 3'd4,
    NEXT  = 3'd5
  } state_t;

  state_t         state;
  logic [2:0]     rr_ptr;     // last granted buffer
  logic [WCW-1:0] word_cnt;   // words completed in current block
  logic [4:0]     burst_cnt;  // position of the current word inside its burst

  // Round-robin grant: first ready buffer after the last grant, wrapping.
  // i runs 1..8, so the last granted buffer itself has the lowest priority.
  logic [2:0] grant;
  logic       grant_vld;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = 1; i <= NUM_BUF; i++) begin
      if (!grant_vld && BRAM_ready_mask[rr_ptr + 3'(i)]) begin
        grant     = rr_ptr + 3'(i);
        grant_vld = 1'b1;
      end
    end
  end

  // Every output is a register, so an asynchronous reset clears all of them
  // immediately. A block in flight is abandoned and is not resumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      rr_ptr                 <= 3'd7;  // buffer 0 wins the first arbitration
      word_cnt               <= '0;
      burst_cnt              <= '0;
      BRAM_Sel               <= '0;
      BRAM_rd_request        <= '0;
      DRAM_Write_Enable      <= 1'b0;
      DRAM_Write_Burst_Begin <= 1'b0;
      DRAM_Write_Burst_Count <= '0;
      DRAM_Write_Addr        <= '0;
      DRAM_Write_Data        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|BRAM_ready_mask) state <= ARB;
        end

        // The mask is sampled here only. Later mask changes cannot move
        // BRAM_Sel until the whole block has been drained.
        ARB: begin
          if (grant_vld) begin
            BRAM_Sel        <= grant;
            rr_ptr          <= grant;
            word_cnt        <= '0;
            burst_cnt       <= '0;
            BRAM_rd_request <= NUM_BUF'(1) << grant;  // high during RD only
            state           <= RD;
          end else begin
            state <= IDLE;
          end
        end

        RD: begin
          BRAM_rd_request <= '0;
          state           <= LATCH;
        end

        LATCH: begin
          DRAM_Write_Data        <= BRAM_rd_data;
          DRAM_Write_Enable      <= 1'b1;
          DRAM_Write_Burst_Begin <= (burst_cnt == 5'd0);
          DRAM_Write_Burst_Count <= BURST_CNT;
          state                  <= WR;
        end

        // Data, address and burst-begin are held until the DRAM takes the word.
        WR: begin
          if (!DRAM_Wait_Request) begin
            DRAM_Write_Enable      <= 1'b0;
            DRAM_Write_Burst_Begin <= 1'b0;
            DRAM_Write_Burst_Count <= '0;
            state                  <= NEXT;
          end
        end

        NEXT: begin
          word_cnt <= word_cnt + 1'b1;
          if (burst_cnt == LAST_BEAT) begin
            burst_cnt       <= '0;
            DRAM_Write_Addr <= DRAM_Write_Addr + ADDR_STEP;  // wraps at 2^25
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (word_cnt == LAST_WORD) begin
            state <= IDLE;
          end else begin
            BRAM_rd_request <= NUM_BUF'(1) << BRAM_Sel;
            state           <= RD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRAM_ADDR_MASK_EN
  // Trigger edge detect. The captured address and timestamp are for an
  // address-masking stage that sits after this block.
  logic        trig_q;
  logic [24:0] mask_addr;
  logic [15:0] mask_ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q      <= 1'b0;
      mask_addr   <= '0;
      mask_ts     <= '0;
      MASK_output <= 1'b0;
    end else begin
      trig_q      <= triggering_status;
      MASK_output <= triggering_status & ~trig_q;
      if (triggering_status && !trig_q) begin
        mask_addr <= DRAM_Write_Addr;
        mask_ts   <= triggering_time_stamp;
      end
    end
  end

  logic unused_mask_regs;
  assign unused_mask_regs = ^{mask_addr, mask_ts};
`else
  assign MASK_output = 1'b0;

  logic unused_trig;
  assign unused_trig = ^{triggering_status, triggering_time_stamp};
`endif

endmodule

// File: tb/tb_dram_addr_gen.sv
module tb_dram_addr_gen;
  localparam int BW = 128;
  localparam int BL = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  triggering_time_stamp;
  logic         triggering_status;
  logic [7:0]   BRAM_ready_mask;
  logic [255:0] BRAM_rd_data;
  logic [7:0]   BRAM_rd_request;
  logic [2:0]   BRAM_Sel;
  logic         DRAM_Wait_Request;
  logic         DRAM_Write_Enable;
  logic         DRAM_Write_Burst_Begin;
  logic [4:0]   DRAM_Write_Burst_Count;
  logic [24:0]  DRAM_Write_Addr;
  logic [255:0] DRAM_Write_Data;
  logic         MASK_output;

  always #5 clk = ~clk;

  dram_addr_gen #(.BLOCK_WORDS(BW), .BURST_LEN(BL)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .triggering_time_stamp  (triggering_time_stamp),
    .triggering_status      (triggering_status),
    .BRAM_ready_mask        (BRAM_ready_mask),
    .BRAM_rd_data           (BRAM_rd_data),
    .BRAM_rd_request        (BRAM_rd_request),
    .BRAM_Sel               (BRAM_Sel),
    .DRAM_Wait_Request      (DRAM_Wait_Request),
    .DRAM_Write_Enable      (DRAM_Write_Enable),
    .DRAM_Write_Burst_Begin (DRAM_Write_Burst_Begin),
    .DRAM_Write_Burst_Count (DRAM_Write_Burst_Count),
    .DRAM_Write_Addr        (DRAM_Write_Addr),
    .DRAM_Write_Data        (DRAM_Write_Data),
    .MASK_output            (MASK_output)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: words are counted globally (g) and within the block (w).
  // The address of a word is the base of the burst that contains it.
  int           last_grant, g, w, blocks_left, stall_left, wait_pct;
  logic [7:0]   blk_mask;
  logic [2:0]   exp_sel;
  bit           garble, stall_req;
  logic [255:0] issued[$];  // data handed out by the BRAM model, not yet written
  logic         p_we, p_wait, p_begin;
  logic [24:0]  p_addr;
  logic [255:0] p_data;

  function automatic logic [2:0] rr_pick(int last, logic [7:0] m);
    for (int i = 1; i <= 8; i++)
      if (m[(last + i) % 8]) return 3'((last + i) % 8);
    return 3'd0;
  endfunction

  task automatic model_reset();
    last_grant = 7; g = 0; w = 0; blocks_left = 0; stall_left = 0;
    stall_req = 0; garble = 0; wait_pct = 0;
    issued.delete();
    p_we = 0; p_wait = 0; p_begin = 0; p_addr = '0; p_data = '0;
  endtask

  // One clock: entered and left at 1 time unit after a rising edge.
  task automatic step();
    logic [255:0] d;
    if (p_we && p_wait) begin
      check("hold_ctl", {DRAM_Write_Enable, DRAM_Write_Burst_Begin, DRAM_Write_Addr},
            {1'b1, p_begin, p_addr});
      check("hold_data", DRAM_Write_Data, p_data);
    end

    if (stall_left > 0) begin
      DRAM_Wait_Request = 1'b1; stall_left--;
    end else if (stall_req && DRAM_Write_Enable) begin
      DRAM_Wait_Request = 1'b1; stall_left = 9; stall_req = 0;
    end else begin
      DRAM_Wait_Request = ($urandom_range(0, 99) < wait_pct);
    end

    if (DRAM_Write_Enable === 1'b1 && DRAM_Wait_Request == 1'b0) begin
      check("write_expected", blocks_left > 0, 1'b1);
      if (w == 0) begin
        exp_sel = rr_pick(last_grant, blk_mask);
        last_grant = exp_sel;
      end
      check("sel", BRAM_Sel, exp_sel);
      check("addr", DRAM_Write_Addr, 25'((g / BL) * BL));
      check("burst_begin", DRAM_Write_Burst_Begin, (w % BL) == 0);
      check("burst_count", DRAM_Write_Burst_Count, BL);
      check("reads_per_word", issued.size(), 1);
      if (issued.size() > 0) check("data", DRAM_Write_Data, issued.pop_front());
      w++; g++;
      if (w == BW) begin
        w = 0;
        blocks_left--;
        BRAM_ready_mask = (blocks_left > 0) ? blk_mask : 8'h00;
      end else if (garble && ($urandom_range(0, 3) == 0)) begin
        BRAM_ready_mask = 8'($urandom);
      end
    end

    if (BRAM_rd_request !== 8'h00) begin
      check("rd_onehot_sel", BRAM_rd_request, 8'b1 << BRAM_Sel);
      check("rd_not_pending", issued.size(), 0);
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      BRAM_rd_data = d;
      issued.push_back(d);
    end

    p_we = DRAM_Write_Enable; p_wait = DRAM_Wait_Request;
    p_begin = DRAM_Write_Burst_Begin; p_addr = DRAM_Write_Addr; p_data = DRAM_Write_Data;
    @(posedge clk); #1;
  endtask

  task automatic run_blocks(int n, logic [7:0] m, bit garb, int wpct);
    int budget;
    blk_mask = m; BRAM_ready_mask = m; blocks_left = n; garble = garb; wait_pct = wpct;
    budget = n * BW * 12 + 200;
    while (blocks_left > 0 && budget > 0) begin step(); budget--; end
    check("blocks_done", blocks_left, 0);
    check("no_stray_reads", issued.size(), 0);
  endtask

  task automatic idle_cycles(int n);
    BRAM_ready_mask = 8'h00; wait_pct = 0;
    for (int i = 0; i < n; i++) step();
    check("idle_we", DRAM_Write_Enable, 1'b0);
    check("idle_rd", BRAM_rd_request, 8'h00);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_rd"},    BRAM_rd_request, 8'h00);
    check({tag, "_sel"},   BRAM_Sel, 3'd0);
    check({tag, "_we"},    DRAM_Write_Enable, 1'b0);
    check({tag, "_begin"}, DRAM_Write_Burst_Begin, 1'b0);
    check({tag, "_count"}, DRAM_Write_Burst_Count, 5'd0);
    check({tag, "_addr"},  DRAM_Write_Addr, 25'd0);
    check({tag, "_data"},  DRAM_Write_Data, 256'd0);
    check({tag, "_mask"},  MASK_output, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    int budget;
    rst = 1'b1;
    triggering_time_stamp = '0; triggering_status = 1'b0;
    BRAM_ready_mask = '0; BRAM_rd_data = '0; DRAM_Wait_Request = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // No ready buffer: nothing happens.
    idle_cycles(10);

    // All ready, no stalls: buffer 0 then buffer 1, addresses 0.. and 128..
    run_blocks(2, 8'hFF, 0, 0);

    // Round-robin wrap: after grant 1, mask {5,2} gives 2, 5, 2.
    run_blocks(3, 8'b0010_0100, 0, 0);

    // A 10-cycle stall on the first word must hold every write output.
    stall_req = 1;
    run_blocks(1, 8'h80, 0, 0);

    // Random masks, random stalls, mask churn in the middle of blocks.
    for (int k = 0; k < 4; k++) begin
      m = 8'($urandom);
      if (m == 8'h00) m = 8'h01;
      run_blocks(1 + int'($urandom_range(0, 1)), m, 1, 30);
    end

    // Trigger edge: pulse only with the mask feature built in.
    idle_cycles(5);
    triggering_time_stamp = 16'h1234;
    triggering_status = 1'b1;
    @(posedge clk); #1;
`ifdef DRAM_ADDR_MASK_EN
    check("mask_pulse", MASK_output, 1'b1);
`else
    check("mask_off", MASK_output, 1'b0);
`endif
    @(posedge clk); #1;
    check("mask_pulse_end", MASK_output, 1'b0);
    triggering_status = 1'b0;

    // Reset at word 40 of a block: outputs clear at once, restart at 0/0.
    blk_mask = 8'hFF; BRAM_ready_mask = 8'hFF; blocks_left = 1; garble = 0; wait_pct = 0;
    budget = BW * 12;
    while (w < 40 && budget > 0) begin step(); budget--; end
    check("reached_word40", w, 40);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run_blocks(1, 8'hFF, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
